updown_mod_counter: RTL and testbench

UPDOWN_MOD_COUNTER -- requirements
Module: updown_mod_counter

---
 rtl/updown_pkg.sv | 12 +
 rtl/updown_next.sv | 61 ++++++
 rtl/updown_mod_counter.sv | 52 +++++
 tb/tb_updown_mod_counter.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/updown_pkg.sv
// Shared direction constants and the clamp helper for the up/down modulo counter.
package updown_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Largest legal count: also the clamp target for out-of-range loads.
  function automatic longint unsigned clamp_value(input longint unsigned mod);
    return mod - 64'd1;
  endfunction

endpackage

// File: rtl/updown_next.sv
// Next-state logic for updown_mod_counter: load > step > hold, with boundary detect.
// UPDOWN_COUNTER_SAT_EN selects saturation instead of wrap-around at the boundary.
module updown_next
  import updown_pkg::*;
#(
  parameter int unsigned     WIDTH = 4,
  parameter longint unsigned MOD   = 16
) (
  input  logic [WIDTH-1:0] q,
  input  logic             select,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q_next,
  output logic             boundary
);

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(clamp_value(MOD));

  logic at_top;
  logic at_bottom;
  logic din_ok;

  assign at_top    = (q == MAX_Q);
  assign at_bottom = (q == '0);
  // Compare at 64 bits so MOD == 2**WIDTH never truncates to zero.
  assign din_ok    = (64'(din) < MOD);

  always_comb begin
    q_next   = q;
    boundary = 1'b0;
    if (load) begin
      q_next = din_ok ? din : MAX_Q;
    end else if (en) begin
      if (select == DIR_UP) begin
        if (!at_top) begin
          q_next = q + WIDTH'(1);
        end else begin
          boundary = 1'b1;
`ifdef UPDOWN_COUNTER_SAT_EN
          q_next = MAX_Q;
`else
          q_next = '0;
`endif
        end
      end else begin
        if (!at_bottom) begin
          q_next = q - WIDTH'(1);
        end else begin
          boundary = 1'b1;
`ifdef UPDOWN_COUNTER_SAT_EN
          q_next = '0;
`else
          q_next = MAX_Q;
`endif
        end
      end
    end
  end

endmodule

// File: rtl/updown_mod_counter.sv
// Up/down modulo-MOD counter with parallel load; wrap pulses one cycle after a boundary step.
// With UPDOWN_COUNTER_SAT_EN the count saturates and wrap carries the saturation flag instead.
module updown_mod_counter
  import updown_pkg::*;
#(
  parameter int unsigned     WIDTH = 4,
  parameter longint unsigned MOD   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             select,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(clamp_value(MOD));

  logic [WIDTH-1:0] q_next;
  logic             boundary;

  updown_next #(
    .WIDTH (WIDTH),
    .MOD   (MOD)
  ) u_next (
    .q        (q),
    .select   (select),
    .en       (en),
    .load     (load),
    .din      (din),
    .q_next   (q_next),
    .boundary (boundary)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q    <= '0;
      wrap <= 1'b0;
    end else begin
      q    <= q_next;
      wrap <= boundary;
    end
  end

  // Terminal count looks at the current direction, not at en.
  assign tc = ((select == DIR_UP) && (q == MAX_Q)) ||
              ((select == DIR_DOWN) && (q == '0));

endmodule

// File: tb/tb_updown_mod_counter.sv
// Directed bench for updown_mod_counter: a MOD=10 instance plus a full-range MOD=16 instance.
module tb_updown_mod_counter;

`ifdef UPDOWN_COUNTER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic       select = 1'b1;
  logic       load = 1'b0;
  logic [3:0] din = 4'd0;
  logic [3:0] q;
  logic       tc;
  logic       wrap;
  logic [3:0] q16;
  logic       tc16;
  logic       wrap16;

  int checks = 0;
  int errors = 0;

  updown_mod_counter #(.WIDTH(4), .MOD(10)) dut (
    .clk(clk), .reset(reset), .en(en), .select(select), .load(load),
    .din(din), .q(q), .tc(tc), .wrap(wrap)
  );

  updown_mod_counter #(.WIDTH(4), .MOD(16)) dut16 (
    .clk(clk), .reset(reset), .en(en), .select(select), .load(load),
    .din(din), .q(q16), .tc(tc16), .wrap(wrap16)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [3:0] v);
    load = 1'b1; en = 1'b0; din = v;
    step();
    load = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    select = 1'b1;
    #1;
    checks++; if (q !== 4'd0) begin errors++; $display("FAIL reset_q: got %0d expected 0", q); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap: got %0b expected 0", wrap); end
    checks++; if (tc !== 1'b0) begin errors++; $display("FAIL reset_tc_up: got %0b expected 0", tc); end
    select = 1'b0;
    #1;
    checks++; if (tc !== 1'b1) begin errors++; $display("FAIL reset_tc_down: got %0b expected 1", tc); end
    step();
    reset = 1'b1;
    do_load(4'd7);
    checks++; if (q !== 4'd7) begin errors++; $display("FAIL load7: got %0d expected 7", q); end
    en = 1'b1; select = 1'b1;
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    checks++; if (q !== 4'd0) begin errors++; $display("FAIL async_reset_q: got %0d expected 0", q); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL async_reset_wrap: got %0b expected 0", wrap); end
    step();
    checks++; if (q !== 4'd0) begin errors++; $display("FAIL reset_held_q: got %0d expected 0", q); end
    reset = 1'b1;
    step();
    checks++; if (q !== 4'd1) begin errors++; $display("FAIL first_edge_q: got %0d expected 1", q); end
    en = 1'b0;
  endtask

  task automatic test_up_wrap();
    do_load(4'd0);
    checks++; if (q !== 4'd0) begin errors++; $display("FAIL up_start: got %0d expected 0", q); end
    en = 1'b1; select = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      step();
      checks++; if (q !== 4'(i)) begin errors++; $display("FAIL up_count[%0d]: got %0d expected %0d", i, q, i); end
      checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL up_wrap_low[%0d]: got %0b expected 0", i, wrap); end
    end
    checks++; if (tc !== 1'b1) begin errors++; $display("FAIL up_tc: got %0b expected 1", tc); end
    step();
    checks++; if (q !== (SAT ? 4'd9 : 4'd0)) begin errors++; $display("FAIL up_wrap_q: got %0d expected %0d", q, SAT ? 9 : 0); end
    checks++; if (wrap !== 1'b1) begin errors++; $display("FAIL up_wrap_pulse: got %0b expected 1", wrap); end
    checks++; if (tc !== SAT) begin errors++; $display("FAIL up_wrap_tc: got %0b expected %0b", tc, SAT); end
    en = 1'b0;
    step();
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL up_wrap_end: got %0b expected 0", wrap); end
    checks++; if (q !== (SAT ? 4'd9 : 4'd0)) begin errors++; $display("FAIL up_hold_q: got %0d expected %0d", q, SAT ? 9 : 0); end
  endtask

  task automatic test_down_wrap();
    do_load(4'd0);
    en = 1'b1; select = 1'b0;
    #1;
    checks++; if (tc !== 1'b1) begin errors++; $display("FAIL down_tc: got %0b expected 1", tc); end
    step();
    checks++; if (q !== (SAT ? 4'd0 : 4'd9)) begin errors++; $display("FAIL down_wrap_q: got %0d expected %0d", q, SAT ? 0 : 9); end
    checks++; if (wrap !== 1'b1) begin errors++; $display("FAIL down_wrap_pulse: got %0b expected 1", wrap); end
    en = 1'b0;
    step();
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL down_wrap_end: got %0b expected 0", wrap); end
    do_load(4'd2);
    en = 1'b1;
    step();
    checks++; if (q !== 4'd1) begin errors++; $display("FAIL down_step: got %0d expected 1", q); end
    en = 1'b0;
  endtask

  task automatic test_load();
    load = 1'b1; en = 1'b1; select = 1'b1; din = 4'd12;
    step();
    checks++; if (q !== 4'd9) begin errors++; $display("FAIL load_clamp: got %0d expected 9", q); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL load_clamp_wrap: got %0b expected 0", wrap); end
    din = 4'd3;
    step();
    checks++; if (q !== 4'd3) begin errors++; $display("FAIL load_priority: got %0d expected 3", q); end
    din = 4'd9;
    step();
    checks++; if (q !== 4'd9) begin errors++; $display("FAIL load_edge9: got %0d expected 9", q); end
    din = 4'd10;
    step();
    checks++; if (q !== 4'd9) begin errors++; $display("FAIL load_edge10: got %0d expected 9", q); end
    load = 1'b0; en = 1'b0;
  endtask

  task automatic test_direction_flip();
    logic [3:0] exp_q [4];
    exp_q[0] = 4'd6; exp_q[1] = 4'd5; exp_q[2] = 4'd6; exp_q[3] = 4'd5;
    do_load(4'd5);
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      select = (i % 2 == 0) ? 1'b1 : 1'b0;
      step();
      checks++; if (q !== exp_q[i]) begin errors++; $display("FAIL flip_q[%0d]: got %0d expected %0d", i, q, exp_q[i]); end
      checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL flip_wrap[%0d]: got %0b expected 0", i, wrap); end
    end
    en = 1'b0; select = 1'b1;
    step();
    step();
    checks++; if (q !== 4'd5) begin errors++; $display("FAIL hold_q: got %0d expected 5", q); end
    checks++; if (tc !== 1'b0) begin errors++; $display("FAIL hold_tc: got %0b expected 0", tc); end
  endtask

  task automatic test_full_range();
    do_load(4'd14);
    checks++; if (q !== 4'd9) begin errors++; $display("FAIL full_clamp10: got %0d expected 9", q); end
    checks++; if (q16 !== 4'd14) begin errors++; $display("FAIL full_load14: got %0d expected 14", q16); end
    en = 1'b1; select = 1'b1;
    step();
    checks++; if (q16 !== 4'd15) begin errors++; $display("FAIL full_q15: got %0d expected 15", q16); end
    checks++; if (tc16 !== 1'b1) begin errors++; $display("FAIL full_tc: got %0b expected 1", tc16); end
    step();
    checks++; if (q16 !== (SAT ? 4'd15 : 4'd0)) begin errors++; $display("FAIL full_wrap_q: got %0d expected %0d", q16, SAT ? 15 : 0); end
    checks++; if (wrap16 !== 1'b1) begin errors++; $display("FAIL full_wrap_pulse: got %0b expected 1", wrap16); end
    en = 1'b0;
    step();
    checks++; if (wrap16 !== 1'b0) begin errors++; $display("FAIL full_wrap_end: got %0b expected 0", wrap16); end
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_load();
    test_direction_flip();
    test_full_range();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
